// File: rtl/mult_shift_add_ctrl.sv
// Shift-and-add unsigned multiplier with control FSM; starts the external iteration
// counter with Load and reports Done only once both WIDTH steps and the K flag are seen.
module mult_shift_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic               Clk,
    input  logic               rst,
    input  logic               St,
    input  logic [WIDTH-1:0]   Mplier,
    input  logic [WIDTH-1:0]   Mcand,
    input  logic               K,
    output logic               Load,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] Product
);

    // state | meaning
    // IDLE  | waiting for St; K ignored
    // RUN   | one add/shift step per clock, K captured into k_seen
    // WAITK | steps finished, waiting for K (or an already-seen K)
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        WAITK = 2'd2
    } state_t;

    localparam int SW = $clog2(WIDTH + 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH - 1);

    state_t             state_q;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q;
    logic [SW-1:0]      step_q;
    logic               k_seen_q;
    logic               load_q, busy_q, done_q;
    logic [2*WIDTH-1:0] product_q;
    logic [WIDTH:0]     sum;

    // acc_q[2*WIDTH] is always 0 between steps, so adding it in keeps the sum exact
    always_comb begin
        sum   = acc_q[2*WIDTH:WIDTH] + {1'b0, (acc_q[0] ? mcand_q : {WIDTH{1'b0}})};
        acc_d = {1'b0, sum, acc_q[WIDTH-1:1]};
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            step_q    <= '0;
            k_seen_q  <= 1'b0;
            load_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            load_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (St) begin
                        acc_q    <= {1'b0, {WIDTH{1'b0}}, Mplier};
                        mcand_q  <= Mcand;
                        step_q   <= '0;
                        k_seen_q <= 1'b0;
                        load_q   <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    acc_q  <= acc_d;
                    step_q <= step_q + SW'(1);
                    if (K) k_seen_q <= 1'b1;
                    if (step_q == LAST_STEP) state_q <= WAITK;
                end
                WAITK: begin
                    if (K || k_seen_q) begin
                        product_q <= acc_q[2*WIDTH-1:0];
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Load    = load_q;
    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Product = product_q;

endmodule

// File: tb/tb_mult_shift_add_ctrl.sv
// Directed bench for mult_shift_add_ctrl: edge-indexed operations with a K pulse model,
// hand-computed products and Done timing, plus reset and back-to-back start cases.
module tb_mult_shift_add_ctrl;

    logic        Clk, rst, St, K;
    logic [15:0] Mplier, Mcand;
    logic        Load, Busy, Done;
    logic [31:0] Product;

    int checks   = 0;
    int failures = 0;

    mult_shift_add_ctrl #(.WIDTH(16)) dut (
        .Clk(Clk), .rst(rst), .St(St), .Mplier(Mplier), .Mcand(Mcand), .K(K),
        .Load(Load), .Busy(Busy), .Done(Done), .Product(Product)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Edge e0 accepts St; K is high only at edge kedge; an optional
    // second St (operands 2x2) is presented at edge st2_edge.
    task automatic op(input logic [15:0] mp, input logic [15:0] mc, input int kedge,
                      input int st2_edge, input int exp_done, input logic [31:0] exp_p,
                      input string tag);
        int loads   = 0;
        int done_at = -1;
        int bad     = 0;
        Mplier = mp;
        Mcand  = mc;
        for (int e = 0; e <= 200 && done_at < 0; e++) begin
            St = (e == 0) || (e == st2_edge);
            if (e == st2_edge) begin
                Mplier = 16'd2;
                Mcand  = 16'd2;
            end
            K = (e == kedge);
            @(posedge Clk);
            @(negedge Clk);
            if (Load) loads++;
            if (Done) done_at = e;
            else if (!Busy) bad++;
        end
        St = 1'b0;
        K  = 1'b0;
        check({tag, "_done_edge"}, 64'(done_at), 64'(exp_done));
        check({tag, "_product"}, 64'(Product), 64'(exp_p));
        check({tag, "_busy_after"}, 64'(Busy), 64'd0);
        check({tag, "_load_count"}, 64'(loads), 64'd1);
        check({tag, "_busy_hold"}, 64'(bad), 64'd0);
        @(negedge Clk);
        check({tag, "_done_pulse"}, 64'(Done), 64'd0);
    endtask

    initial begin
        int loads;
        int dones;
        int d_edge [2];
        logic [31:0] prods [2];

        rst = 1'b1; St = 1'b0; K = 1'b0; Mplier = '0; Mcand = '0;
        repeat (2) @(negedge Clk);
        check("rst_load", 64'(Load), 64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_product", 64'(Product), 64'd0);
        rst = 1'b0;
        @(negedge Clk);

        op(16'd5, 16'd3, 32, -1, 32, 32'd15, "op5x3");
        op(16'hFFFF, 16'hFFFF, 5, -1, 17, 32'hFFFE0001, "opFFFF");
        op(16'd0, 16'hABCD, 116, -1, 116, 32'd0, "op0_late_k");
        op(16'd7, 16'd9, 3, 4, 17, 32'd63, "op7x9_st2");
        op(16'd2, 16'd2, 16, -1, 17, 32'd4, "op2x2");

        // Reset right after Load rises: must clear outputs without waiting for a clock
        St = 1'b1; Mplier = 16'h1234; Mcand = 16'h0100;
        @(posedge Clk);
        @(negedge Clk);
        St = 1'b0;
        check("pre_rst_load", 64'(Load), 64'd1);
        rst = 1'b1;
        #1;
        check("async_rst_load", 64'(Load), 64'd0);
        check("async_rst_busy", 64'(Busy), 64'd0);
        check("async_rst_product", 64'(Product), 64'd0);
        @(negedge Clk);
        rst = 1'b0;

        // Reset deep in RUN, then K pulses must not produce a Done
        St = 1'b1;
        for (int e = 0; e < 8; e++) begin
            @(posedge Clk);
            @(negedge Clk);
            St = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 64'(Busy), 64'd0);
        check("mid_rst_done", 64'(Done), 64'd0);
        check("mid_rst_product", 64'(Product), 64'd0);
        @(negedge Clk);
        rst = 1'b0;
        dones = 0;
        for (int e = 0; e < 24; e++) begin
            K = (e % 5 == 1);
            @(posedge Clk);
            @(negedge Clk);
            if (Done) dones++;
        end
        K = 1'b0;
        check("post_rst_no_done", 64'(dones), 64'd0);
        op(16'h1234, 16'h0100, 3, -1, 17, 32'h00123400, "op1234");

        // St held high: second op accepted at e18, right after Done at e17
        loads = 0; dones = 0;
        d_edge[0] = -1; d_edge[1] = -1; prods[0] = '0; prods[1] = '0;
        St = 1'b1; Mplier = 16'd2; Mcand = 16'd3;
        for (int e = 0; e <= 60 && dones < 2; e++) begin
            K = (e == 3) || (e == 21);
            @(posedge Clk);
            @(negedge Clk);
            if (Load) loads++;
            if (Done) begin
                d_edge[dones] = e;
                prods[dones]  = Product;
                dones++;
                Mplier = 16'd4; Mcand = 16'd5;
            end
        end
        St = 1'b0; K = 1'b0;
        check("b2b_loads", 64'(loads), 64'd2);
        check("b2b_done0_edge", 64'(d_edge[0]), 64'd17);
        check("b2b_product0", 64'(prods[0]), 64'd6);
        check("b2b_done1_edge", 64'(d_edge[1]), 64'd35);
        check("b2b_product1", 64'(prods[1]), 64'd20);
        repeat (3) @(negedge Clk);
        check("b2b_idle_busy", 64'(Busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_shift_add_ctrl.md
Name: mult_shift_add_ctrl

Overview:
- Sequential shift-and-add multiplier: control FSM plus datapath for the Multiplicador path.
- It is the stage directly upstream of the iteration counter. It pulses Load to start that counter and consumes the counter's terminal flag K.
- It performs one add/shift step per clock. It reports completion only after both the internal step sequence and K have been seen.

Parameters:
WIDTH, 16, operand width in bits; Product is 2*WIDTH bits

Ports:
Clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
St  input  1  start request, sampled only in IDLE
Mplier  input  WIDTH  multiplier operand, captured when St is accepted
Mcand  input  WIDTH  multiplicand operand, captured when St is accepted
K  input  1  terminal flag from the iteration counter; one-cycle pulse
Load  output  1  one-cycle pulse that starts/clears the iteration counter
Busy  output  1  high while an operation is in progress (RUN or WAITK)
Done  output  1  one-cycle completion pulse
Product  output  2*WIDTH  result; holds its value until the next completion

Behaviour:
- Interface (already decided): one clock, Clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state = IDLE.
  - Load = 0, Busy = 0, Done = 0, Product = 0.
  - Internal accumulator ACC (2*WIDTH+1 bits) = 0, step counter = 0, k_seen = 0.
- All outputs are registered.
- IDLE:
  - At an edge with St = 1: ACC <= {carry=0, WIDTH zeros, Mplier}; Mcand is latched; step <= 0; k_seen <= 0; Load <= 1; Busy <= 1; state -> RUN.
  - K is ignored in IDLE.
- RUN: one step per edge.
  - If ACC[0] = 1: upper sum = ACC[2W-1:W] + Mcand, computed WIDTH+1 bits wide with no truncation.
  - ACC <= {carry, upper sum, lower} shifted right by 1; the carry shifts into the top bit.
  - step <= step + 1.
  - Load <= 0 after its single cycle.
  - If K = 1 at this edge: k_seen <= 1.
  - At the edge that completes step WIDTH: state -> WAITK.
- WAITK:
  - At an edge with K = 1 or k_seen = 1: Product <= ACC[2W-1:0]; Done <= 1 for exactly one cycle; Busy <= 0; state -> IDLE.
  - Otherwise WAITK holds indefinitely, with no timeout.
- Latency:
  - St is accepted at edge e0 and Load is high during e0..e1.
  - Steps execute at edges e1..eW.
  - Earliest Done is at edge eW+1 (K already seen, or K high at eW+1). Done is then visible in cycle eW+1..eW+2.
- St while Busy = 1: ignored; operands are not re-captured and no extra Load is issued.
- St held high across a Done: a new operation is accepted at the first edge in IDLE, which is the edge after the one that raised Done.
- Multiple K pulses during RUN: k_seen is sticky; extra pulses have no further effect.
- Reset mid-operation: everything returns to its reset values immediately.
  - Product is cleared to 0.
  - No Done is issued.
  - Load deasserts asynchronously.
- Arithmetic is unsigned; the full 2*WIDTH-bit product is exact and there is no overflow.

Test Plan:
- WIDTH=16, Mplier=5, Mcand=3, St one cycle; bench model pulses K 32 edges after Load -> Load high exactly 1 cycle; Done 1 cycle after K edge; Product=15; Busy low after Done.
- Mplier=0xFFFF, Mcand=0xFFFF, K pulsed during RUN (edge e5) -> Done at edge e17 (WIDTH+1); Product=0xFFFE0001.
- Mplier=0, Mcand=0xABCD; K delayed 100 cycles after step WIDTH -> stays in WAITK with Busy=1 and Done=0 until K; then Product=0 and one Done pulse.
- Start 7x9; pulse St again with 2x2 at edge e4 -> second request ignored, no second Load; Product=63; then a fresh St yields 4.
- Start 0x1234x0x0100; assert rst at e8 -> Load/Busy/Done/Product all 0 asynchronously; later K pulse gives no Done; next operation 0x1234x0x0100 -> Product=0x00123400.
- St held high continuously, operands 2x3 then 4x5 -> two back-to-back operations with one Load per operation; Products 6 then 20.
